// File: rtl/axis_fifo_pkt.sv
`timescale 1ns/1ps
// Single-clock AXI4-Stream FIFO with registered first-word-fall-through output,
// optional store-and-forward packet mode with an oversize-packet drain escape.
module axis_fifo_pkt #(
  parameter int AXIS_BUS_WIDTH = 16,
  parameter int DEPTH_WIDTH    = 10,
  parameter bit PACKET_MODE    = 1'b0,
  parameter int AFULL_THRESH   = (1 << DEPTH_WIDTH) - 4,
  parameter int AEMPTY_THRESH  = 4
) (
  input  logic                      m_axi_aclk,
  input  logic                      m_axi_areset,
  input  logic                      flush,
  input  logic [AXIS_BUS_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [AXIS_BUS_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [DEPTH_WIDTH:0]      level,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [DEPTH_WIDTH:0]      pkt_count,
  output logic                      oversize
);
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam int LW    = DEPTH_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic {ST_IDLE, ST_DRAIN} drain_state_e;

  logic [AXIS_BUS_WIDTH:0]   mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]             level_q, level_d, pkt_count_q, pkt_count_d;
  logic [AXIS_BUS_WIDTH-1:0] tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic                      oversize_q, oversize_d;
  drain_state_e              state_q, state_d;

  logic                      clr, wr_en, out_xfer, pop, release_ok, mem_nonempty;
  logic [AXIS_BUS_WIDTH:0]   head;

  assign clr           = m_axi_areset | flush;
  assign s_axis_tready = ~clr & (level_q < DEPTH_L);
  assign wr_en         = s_axis_tvalid & s_axis_tready;
  assign out_xfer      = tvalid_q & m_axis_tready;
  // level counts the output register too, so memory is non-empty when level exceeds it
  assign mem_nonempty  = (level_q != LW'(tvalid_q));
  assign head          = mem_q[rd_ptr_q];
  assign release_ok    = !PACKET_MODE || (pkt_count_q != '0) || (state_q == ST_DRAIN);
  assign pop           = mem_nonempty & (~tvalid_q | m_axis_tready) & release_ok;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    tvalid_d    = tvalid_q;
    level_d     = level_q + LW'(wr_en) - LW'(out_xfer);
    pkt_count_d = '0;
    state_d     = state_q;
    oversize_d  = 1'b0;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      tdata_d  = head[AXIS_BUS_WIDTH-1:0];
      tlast_d  = head[AXIS_BUS_WIDTH];
      tvalid_d = 1'b1;
    end else if (out_xfer) begin
      tvalid_d = 1'b0;
    end

    if (PACKET_MODE) begin
      pkt_count_d = pkt_count_q + LW'(wr_en & s_axis_tlast) - LW'(pop & head[AXIS_BUS_WIDTH]);
      // A full FIFO with no complete packet can never release; drain it until tlast arrives
      case (state_q)
        ST_IDLE: if (level_q == DEPTH_L && pkt_count_q == '0) begin
          state_d    = ST_DRAIN;
          oversize_d = 1'b1;
        end
        ST_DRAIN: if (wr_en & s_axis_tlast) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      tdata_d     = '0;
      tlast_d     = 1'b0;
      tvalid_d    = 1'b0;
      level_d     = '0;
      pkt_count_d = '0;
      state_d     = ST_IDLE;
      oversize_d  = 1'b0;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      level_q     <= '0;
      pkt_count_q <= '0;
      state_q     <= ST_IDLE;
      oversize_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      tvalid_q    <= tvalid_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
      state_q     <= state_d;
      oversize_q  <= oversize_d;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign level         = level_q;
  assign pkt_count     = pkt_count_q;
  assign oversize      = oversize_q;
  assign almost_full   = int'(level_q) >= AFULL_THRESH;
  assign almost_empty  = int'(level_q) <= AEMPTY_THRESH;
endmodule

// File: tb/tb_axis_fifo_pkt.sv
`timescale 1ns/1ps
// Bench for axis_fifo_pkt: a cut-through instance (depth 8) and a packet-mode
// instance (depth 4) checked against a per-instance expected-beat queue.
module tb_axis_fifo_pkt;
  localparam int W     = 16;
  localparam int AF_CT = 4, AE_CT = 4, AF_PK = 3, AE_PK = 1;
  localparam int N_BEATS = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // index 0 = cut-through instance, 1 = packet-mode instance
  logic         flush[2], s_valid[2], s_last[2], m_ready[2];
  logic [W-1:0] s_data[2], m_data[2];
  logic         s_ready[2], m_valid[2], m_last[2], afull[2], aempty[2], ovs[2];
  logic [3:0]   lvl_ct, pkc_ct;
  logic [2:0]   lvl_pk, pkc_pk;
  logic [3:0]   level_w[2], pktc_w[2];

  assign level_w[0] = lvl_ct;
  assign level_w[1] = {1'b0, lvl_pk};
  assign pktc_w[0]  = pkc_ct;
  assign pktc_w[1]  = {1'b0, pkc_pk};

  axis_fifo_pkt #(.AXIS_BUS_WIDTH(W), .DEPTH_WIDTH(3), .PACKET_MODE(1'b0),
                  .AFULL_THRESH(AF_CT), .AEMPTY_THRESH(AE_CT)) dut_ct (
    .m_axi_aclk(clk), .m_axi_areset(rst), .flush(flush[0]),
    .s_axis_tdata(s_data[0]), .s_axis_tvalid(s_valid[0]), .s_axis_tlast(s_last[0]),
    .s_axis_tready(s_ready[0]), .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]),
    .m_axis_tlast(m_last[0]), .m_axis_tready(m_ready[0]), .level(lvl_ct),
    .almost_full(afull[0]), .almost_empty(aempty[0]), .pkt_count(pkc_ct), .oversize(ovs[0]));

  axis_fifo_pkt #(.AXIS_BUS_WIDTH(W), .DEPTH_WIDTH(2), .PACKET_MODE(1'b1),
                  .AFULL_THRESH(AF_PK), .AEMPTY_THRESH(AE_PK)) dut_pk (
    .m_axi_aclk(clk), .m_axi_areset(rst), .flush(flush[1]),
    .s_axis_tdata(s_data[1]), .s_axis_tvalid(s_valid[1]), .s_axis_tlast(s_last[1]),
    .s_axis_tready(s_ready[1]), .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]),
    .m_axis_tlast(m_last[1]), .m_axis_tready(m_ready[1]), .level(lvl_pk),
    .almost_full(afull[1]), .almost_empty(aempty[1]), .pkt_count(pkc_pk), .oversize(ovs[1]));

  int vec_cnt = 0, miss_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: accepted input beats queued, popped on each output transfer
  logic [W:0] exp_q_ct[$], exp_q_pk[$];
  int         lvl_m[2], acc_cnt[2], ov_cnt[2];
  int         lvl_max;
  logic       pend[2], held_v[2];
  logic [W:0] held[2];
  logic       mon_en = 1'b0;

  always @(negedge clk) begin
    logic [W:0] e;
    bit         empty;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("level%0d", d), 32'(level_w[d]), 32'(lvl_m[d]));
        chk($sformatf("afull%0d", d), 32'(afull[d]), 32'(lvl_m[d] >= (d == 0 ? AF_CT : AF_PK)));
        chk($sformatf("aempty%0d", d), 32'(aempty[d]), 32'(lvl_m[d] <= (d == 0 ? AE_CT : AE_PK)));
        if (held_v[d]) begin
          chk($sformatf("stall_valid%0d", d), 32'(m_valid[d]), 32'd1);
          chk($sformatf("stall_beat%0d", d), 32'({m_last[d], m_data[d]}), 32'(held[d]));
        end
        if (ovs[d]) ov_cnt[d]++;
        if (d == 1 && int'(level_w[1]) > lvl_max) lvl_max = int'(level_w[1]);
        if (flush[d]) begin
          if (d == 0) exp_q_ct.delete(); else exp_q_pk.delete();
          lvl_m[d]  = 0;
          held_v[d] = 1'b0;
          pend[d]   = 1'b0;
        end else begin
          if (m_valid[d] && m_ready[d]) begin
            empty = (d == 0) ? (exp_q_ct.size() == 0) : (exp_q_pk.size() == 0);
            if (empty) begin
              vec_cnt++;
              miss_cnt++;
              $display("FAIL out_beat%0d: got %0h expected none", d, {m_last[d], m_data[d]});
            end else begin
              e = (d == 0) ? exp_q_ct.pop_front() : exp_q_pk.pop_front();
              chk($sformatf("out_beat%0d", d), 32'({m_last[d], m_data[d]}), 32'(e));
            end
            lvl_m[d]--;
          end
          if (s_valid[d] && s_ready[d]) begin
            if (d == 0) exp_q_ct.push_back({s_last[d], s_data[d]});
            else        exp_q_pk.push_back({s_last[d], s_data[d]});
            lvl_m[d]++;
            acc_cnt[d]++;
          end
          held_v[d] = m_valid[d] && !m_ready[d];
          held[d]   = {m_last[d], m_data[d]};
          pend[d]   = s_valid[d] && !s_ready[d];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted, with a cycle budget
  task automatic send(input int d, input logic [W-1:0] data, input logic last);
    logic ok;
    int   n;
    n = 0;
    s_data[d] = data; s_last[d] = last; s_valid[d] = 1'b1;
    forever begin
      @(negedge clk);
      ok = s_ready[d];
      tick();
      if (ok) break;
      if (++n > 200) begin
        vec_cnt++;
        miss_cnt++;
        $display("FAIL send_timeout%0d: got no accept expected accept", d);
        break;
      end
    end
    s_valid[d] = 1'b0; s_last[d] = 1'b0;
  endtask

  typedef struct {
    logic sv; logic [W-1:0] sd; logic mr;
    logic [3:0] lvl; logic sr, af, ae, mv; logic [W-1:0] md;
  } vec_t;
  vec_t t1[16];

  function automatic vec_t mk(logic sv, logic [W-1:0] sd, logic mr, logic [3:0] lvl,
                              logic sr, logic af, logic ae, logic mv, logic [W-1:0] md);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.lvl = lvl;
    v.sr = sr; v.af = af; v.ae = ae; v.mv = mv; v.md = md;
    return v;
  endfunction

  initial begin
    int cyc;
    //            sv  sd   mr  lvl sr af ae mv md
    t1[0]  = mk(1, 16'h1, 0, 1, 1, 0, 1, 0, 16'h0);
    t1[1]  = mk(1, 16'h2, 0, 2, 1, 0, 1, 1, 16'h1);
    t1[2]  = mk(1, 16'h3, 0, 3, 1, 0, 1, 1, 16'h1);
    t1[3]  = mk(1, 16'h4, 0, 4, 1, 1, 1, 1, 16'h1);
    t1[4]  = mk(1, 16'h5, 0, 5, 1, 1, 0, 1, 16'h1);
    t1[5]  = mk(1, 16'h6, 0, 6, 1, 1, 0, 1, 16'h1);
    t1[6]  = mk(1, 16'h7, 0, 7, 1, 1, 0, 1, 16'h1);
    t1[7]  = mk(1, 16'h8, 0, 8, 0, 1, 0, 1, 16'h1);
    t1[8]  = mk(1, 16'h9, 1, 7, 1, 1, 0, 1, 16'h2);
    t1[9]  = mk(0, 16'h0, 1, 6, 1, 1, 0, 1, 16'h3);
    t1[10] = mk(0, 16'h0, 1, 5, 1, 1, 0, 1, 16'h4);
    t1[11] = mk(0, 16'h0, 1, 4, 1, 1, 1, 1, 16'h5);
    t1[12] = mk(0, 16'h0, 1, 3, 1, 0, 1, 1, 16'h6);
    t1[13] = mk(0, 16'h0, 1, 2, 1, 0, 1, 1, 16'h7);
    t1[14] = mk(0, 16'h0, 1, 1, 1, 0, 1, 1, 16'h8);
    t1[15] = mk(0, 16'h0, 1, 0, 1, 0, 1, 0, 16'h0);

    for (int d = 0; d < 2; d++) begin
      flush[d] = 0; s_valid[d] = 0; s_last[d] = 0; m_ready[d] = 0; s_data[d] = '0;
      lvl_m[d] = 0; acc_cnt[d] = 0; ov_cnt[d] = 0; pend[d] = 0; held_v[d] = 0; held[d] = '0;
    end
    lvl_max = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_tready", 32'(s_ready[d]), 32'd0);
      chk("rst_tvalid", 32'(m_valid[d]), 32'd0);
      chk("rst_tlast", 32'(m_last[d]), 32'd0);
      chk("rst_tdata", 32'(m_data[d]), 32'd0);
      chk("rst_level", 32'(level_w[d]), 32'd0);
      chk("rst_pktcnt", 32'(pktc_w[d]), 32'd0);
      chk("rst_afull", 32'(afull[d]), 32'd0);
      chk("rst_aempty", 32'(aempty[d]), 32'd1);
      chk("rst_oversize", 32'(ovs[d]), 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk("post_rst_tready", 32'(s_ready[d]), 32'd1);
    mon_en = 1'b1;
    tick();

    // T1: fill cut-through to full with output stalled, then drain
    for (int i = 0; i < 16; i++) begin
      s_valid[0] = t1[i].sv; s_data[0] = t1[i].sd; m_ready[0] = t1[i].mr;
      tick();
      chk($sformatf("t1_level[%0d]", i), 32'(lvl_ct), 32'(t1[i].lvl));
      chk($sformatf("t1_tready[%0d]", i), 32'(s_ready[0]), 32'(t1[i].sr));
      chk($sformatf("t1_afull[%0d]", i), 32'(afull[0]), 32'(t1[i].af));
      chk($sformatf("t1_aempty[%0d]", i), 32'(aempty[0]), 32'(t1[i].ae));
      chk($sformatf("t1_tvalid[%0d]", i), 32'(m_valid[0]), 32'(t1[i].mv));
      if (t1[i].mv) chk($sformatf("t1_tdata[%0d]", i), 32'(m_data[0]), 32'(t1[i].md));
    end
    s_valid[0] = 0; m_ready[0] = 0;

    // T4: steady 1-in/1-out at level 2
    s_valid[0] = 1; s_data[0] = 16'h0100;
    tick();
    s_data[0] = 16'h0101;
    tick();
    chk("t4_fill_level", 32'(lvl_ct), 32'd2);
    m_ready[0] = 1;
    for (int i = 0; i < 100; i++) begin
      s_data[0] = 16'(16'h0200 + i);
      tick();
      chk("t4_level", 32'(lvl_ct), 32'd2);
      chk("t4_tvalid", 32'(m_valid[0]), 32'd1);
    end
    s_valid[0] = 0;
    repeat (4) tick();
    chk("t4_empty", 32'(lvl_ct), 32'd0);

    // T5 cut-through: flush at level 5 with a concurrent input beat
    m_ready[0] = 0;
    for (int i = 0; i < 5; i++) begin
      s_valid[0] = 1; s_data[0] = 16'(16'h0500 + i);
      tick();
    end
    chk("t5_level5", 32'(lvl_ct), 32'd5);
    flush[0] = 1; s_data[0] = 16'hDEAD; s_valid[0] = 1;
    #1;
    chk("t5_flush_tready", 32'(s_ready[0]), 32'd0);
    tick();
    chk("t5_level", 32'(lvl_ct), 32'd0);
    chk("t5_tvalid", 32'(m_valid[0]), 32'd0);
    chk("t5_aempty", 32'(aempty[0]), 32'd1);
    flush[0] = 0; s_valid[0] = 0;
    #1;
    chk("t5_tready_after", 32'(s_ready[0]), 32'd1);
    repeat (3) tick();
    chk("t5_not_stored", 32'(m_valid[0]), 32'd0);

    // T2: packet held back until its tlast is written
    m_ready[1] = 1;
    send(1, 16'h0A01, 0);
    chk("t2_hold_a", 32'(m_valid[1]), 32'd0);
    tick();
    chk("t2_hold_b", 32'(m_valid[1]), 32'd0);
    send(1, 16'h0A02, 0);
    chk("t2_hold_c", 32'(m_valid[1]), 32'd0);
    tick();
    chk("t2_hold_d", 32'(m_valid[1]), 32'd0);
    send(1, 16'h0A03, 1);
    chk("t2_hold_e", 32'(m_valid[1]), 32'd0);
    chk("t2_pkt1", 32'(pktc_w[1]), 32'd1);
    tick();
    chk("t2_out1", 32'(m_valid[1]), 32'd1);
    chk("t2_pkt1b", 32'(pktc_w[1]), 32'd1);
    tick();
    chk("t2_out2", 32'(m_valid[1]), 32'd1);
    tick();
    chk("t2_out3", 32'(m_valid[1]), 32'd1);
    chk("t2_out3_last", 32'(m_last[1]), 32'd1);
    chk("t2_pkt0", 32'(pktc_w[1]), 32'd0);
    tick();
    chk("t2_done", 32'(m_valid[1]), 32'd0);

    // T3: 6-word packet into a 4-word FIFO forces the drain escape
    ov_cnt[1] = 0; lvl_max = 0;
    for (int i = 1; i <= 6; i++) send(1, 16'(16'h0B00 + i), (i == 6));
    cyc = 0;
    while (lvl_pk != 0 && cyc < 30) begin
      tick();
      cyc++;
    end
    chk("t3_drained", 32'(lvl_pk), 32'd0);
    chk("t3_oversize_pulses", 32'(ov_cnt[1]), 32'd1);
    chk("t3_level_max", 32'(lvl_max), 32'd4);
    chk("t3_pkt0", 32'(pktc_w[1]), 32'd0);
    send(1, 16'h0C01, 0);
    repeat (3) begin
      tick();
      chk("t3_drain_exited", 32'(m_valid[1]), 32'd0);
    end
    send(1, 16'h0C02, 1);
    repeat (4) tick();
    chk("t3_pkt_level", 32'(lvl_pk), 32'd0);

    // T5 packet mode: flush discards a held packet and a partial one
    m_ready[1] = 0;
    send(1, 16'h0D0A, 0);
    send(1, 16'h0D0B, 1);
    send(1, 16'h0D0C, 0);
    tick();
    chk("t5p_level", 32'(lvl_pk), 32'd3);
    chk("t5p_pkt", 32'(pktc_w[1]), 32'd1);
    chk("t5p_tvalid", 32'(m_valid[1]), 32'd1);
    flush[1] = 1; s_valid[1] = 1; s_data[1] = 16'hDEAD; s_last[1] = 1;
    tick();
    chk("t5p_level0", 32'(lvl_pk), 32'd0);
    chk("t5p_pkt0", 32'(pktc_w[1]), 32'd0);
    chk("t5p_tvalid0", 32'(m_valid[1]), 32'd0);
    flush[1] = 0; s_valid[1] = 0; s_last[1] = 0;
    m_ready[1] = 1;
    send(1, 16'h0D01, 1);
    repeat (4) tick();
    chk("t5p_after", 32'(lvl_pk), 32'd0);

    // T6: random valid/ready stalls on both instances
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    cyc = 0;
    while (cyc < 40000 && (acc_cnt[0] < N_BEATS || acc_cnt[1] < N_BEATS)) begin
      for (int d = 0; d < 2; d++) begin
        if (acc_cnt[d] >= N_BEATS && !pend[d]) s_valid[d] = 0;
        else if (!pend[d]) begin
          s_valid[d] = ($urandom_range(0, 3) != 0);
          s_data[d]  = 16'($urandom);
          s_last[d]  = ($urandom_range(0, 2) == 0);
        end
        m_ready[d] = ($urandom_range(0, 3) != 0);
      end
      tick();
      cyc++;
    end
    chk("t6_beats_done", 32'(acc_cnt[0] >= N_BEATS && acc_cnt[1] >= N_BEATS), 32'd1);
    s_valid[0] = 0; s_valid[1] = 0;
    m_ready[0] = 1; m_ready[1] = 1;
    send(1, 16'hEEEE, 1);
    cyc = 0;
    while ((lvl_ct != 0 || lvl_pk != 0) && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("t6_ct_empty", 32'(lvl_ct), 32'd0);
    chk("t6_pk_empty", 32'(lvl_pk), 32'd0);
    chk("t6_ct_queue", 32'(exp_q_ct.size()), 32'd0);
    chk("t6_pk_queue", 32'(exp_q_pk.size()), 32'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
